// File: rtl/buzz_pkg.sv
// Shared types and helpers for the buzzer note player and its command FIFO.
// No logic; state encoding, ms prescaler divide and command width only.
package buzz_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2
    } state_t;

    // Clock cycles per millisecond tick; never below one.
    function automatic int ms_div(input int clk_hz);
        return (clk_hz / 1000 > 0) ? clk_hz / 1000 : 1;
    endfunction

    // Packed command is {rest, half_period, dur_ms}.
    function automatic int cmd_width(input int hp_w, input int dur_w);
        return 1 + hp_w + dur_w;
    endfunction

endpackage

// File: rtl/buzz_cmd_fifo.sv
// Purpose: single-clock command FIFO, synchronous active-low reset.
// Latency: a push is visible at the head (pop_dat, level) one cycle after the write edge.
// Backpressure: pushes while full and pops while empty are dropped; caller gates on full/empty.
module buzz_cmd_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop_vld,
    output logic [W-1:0]               pop_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          do_push, do_pop;

    assign full    = (level_q == LW'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign pop_dat = mem_q[rd_ptr_q];
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/buzz_note_player.sv
// Purpose: plays queued {rest, half_period, dur_ms} notes as a square wave on buzz; BUZZ_GAP_EN adds an articulation gap.
// Latency: push at edge N -> LOAD at N+1 -> PLAY at N+2; buzz/playing/note_done registered (note_done one cycle after the final tick).
// Backpressure: note_ready = !full from the registered FIFO level; enable=0 freezes playback but still accepts pushes.
module buzz_note_player
    import buzz_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int HP_W       = 20,
    parameter int DUR_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_MS     = 10
) (
    input  logic                            clk_50MHz,
    input  logic                            reset_button_n,
    input  logic                            note_valid,
    output logic                            note_ready,
    input  logic [HP_W-1:0]                 note_half_period,
    input  logic [DUR_W-1:0]                note_dur_ms,
    input  logic                            note_rest,
    input  logic                            enable,
    output logic                            buzz,
    output logic                            playing,
    output logic                            note_done,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int DIV   = ms_div(CLK_HZ);
    localparam int PS_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CMD_W = cmd_width(HP_W, DUR_W);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(DIV - 1);

    typedef struct packed {
        logic             rest;
        logic [HP_W-1:0]  hp;
        logic [DUR_W-1:0] dur;
    } cmd_t;

    cmd_t             push_cmd, pop_cmd;
    logic [CMD_W-1:0] pop_dat;
    logic             fifo_full, fifo_empty, pop_vld;
    logic [LVL_W-1:0] level;

    state_t           state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d;
    logic             rest_q, rest_d;
    logic [DUR_W-1:0] rem_q, rem_d;
    logic [HP_W-1:0]  tone_q, tone_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic             phase_q, phase_d;
    logic             buzz_q, buzz_d;
    logic             playing_q, playing_d;
    logic             done_q, done_d;
    logic             tick, silent, gap_on;

    assign push_cmd = '{rest: note_rest, hp: note_half_period, dur: note_dur_ms};
    assign pop_cmd  = cmd_t'(pop_dat);

    buzz_cmd_fifo #(
        .W     (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_50MHz),
        .rst_n    (reset_button_n),
        .push_vld (note_valid),
        .push_dat (push_cmd),
        .pop_vld  (pop_vld),
        .pop_dat  (pop_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (level)
    );

    assign note_ready = !fifo_full;
    assign fifo_level = level;
    assign buzz       = buzz_q;
    assign playing    = playing_q;
    assign note_done  = done_q;

`ifdef BUZZ_GAP_EN
    localparam logic [DUR_W-1:0] GAP_V = DUR_W'(GAP_MS);
`else
    localparam int gap_ms_unused = GAP_MS;
`endif

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        rest_d  = rest_q;
        rem_d   = rem_q;
        tone_d  = tone_q;
        presc_d = presc_q;
        phase_d = phase_q;
        done_d  = 1'b0;
        pop_vld = 1'b0;
        tick    = (presc_q == PS_MAX);

        case (state_q)
            IDLE: begin
                if (!fifo_empty && enable) state_d = LOAD;
            end
            LOAD: begin
                if (enable) begin
                    pop_vld = 1'b1;
                    rest_d  = pop_cmd.rest;
                    hp_d    = pop_cmd.hp;
                    rem_d   = pop_cmd.dur;
                    tone_d  = '0;
                    presc_d = '0;
                    phase_d = 1'b0;
                    if (pop_cmd.dur != '0) begin
                        state_d = PLAY;
                    end else begin
                        // Zero-length note: finish immediately, chain if more are queued.
                        done_d  = 1'b1;
                        state_d = (level > LVL_W'(1)) ? LOAD : IDLE;
                    end
                end
            end
            PLAY: begin
                if (enable) begin
                    if (tone_q == hp_q) begin
                        tone_d  = '0;
                        phase_d = !phase_q;
                    end else begin
                        tone_d = tone_q + 1'b1;
                    end
                    presc_d = tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        rem_d = rem_q - 1'b1;
                        if (rem_q == DUR_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = fifo_empty ? IDLE : LOAD;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        silent = rest_d || (hp_d < HP_W'(2));
`ifdef BUZZ_GAP_EN
        gap_on = (rem_d <= GAP_V);
`else
        gap_on = 1'b0;
`endif
        buzz_d    = (state_d == PLAY) && enable && phase_d && !silent && !gap_on;
        playing_d = (state_d == PLAY);
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_button_n) begin
            state_q   <= IDLE;
            hp_q      <= '0;
            rest_q    <= 1'b0;
            rem_q     <= '0;
            tone_q    <= '0;
            presc_q   <= '0;
            phase_q   <= 1'b0;
            buzz_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hp_q      <= hp_d;
            rest_q    <= rest_d;
            rem_q     <= rem_d;
            tone_q    <= tone_d;
            presc_q   <= presc_d;
            phase_q   <= phase_d;
            buzz_q    <= buzz_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_buzz_note_player.sv
// Scoreboard bench for buzz_note_player at 10 cycles per ms and a 4-entry FIFO.
// Expected buzz rising edges and note_done pulses are queued with their cycle; a monitor checks them.
module tb_buzz_note_player;
    localparam int HP_W  = 20;
    localparam int DUR_W = 16;
    localparam int LVL_W = $clog2(4 + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             note_valid;
    logic             note_ready;
    logic [HP_W-1:0]  note_half_period;
    logic [DUR_W-1:0] note_dur_ms;
    logic             note_rest;
    logic             enable;
    logic             buzz;
    logic             playing;
    logic             note_done;
    logic [LVL_W-1:0] fifo_level;

    buzz_note_player #(
        .CLK_HZ     (10_000),
        .HP_W       (HP_W),
        .DUR_W      (DUR_W),
        .FIFO_DEPTH (4),
        .GAP_MS     (1)
    ) dut (
        .clk_50MHz        (clk),
        .reset_button_n   (rst_n),
        .note_valid       (note_valid),
        .note_ready       (note_ready),
        .note_half_period (note_half_period),
        .note_dur_ms      (note_dur_ms),
        .note_rest        (note_rest),
        .enable           (enable),
        .buzz             (buzz),
        .playing          (playing),
        .note_done        (note_done),
        .fifo_level       (fifo_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit kind;   // 0 = buzz rise, 1 = note_done
        int at;
    } ev_t;

    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    logic buzz_prev = 1'b0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic expect_ev(input bit kind, input int at);
        exp_q.push_back('{kind: kind, at: at});
    endtask

    task automatic got_event(input bit kind);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event kind=%0d at cycle %0d, required none", kind, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.at != cyc) begin
                errors++;
                $display("FAIL event got kind=%0d @%0d, required kind=%0d @%0d", kind, cyc, e.kind, e.at);
            end
        end
    endtask

    always @(negedge clk) begin
        if (buzz === 1'b1 && buzz_prev === 1'b0) got_event(1'b0);
        if (note_done === 1'b1) got_event(1'b1);
        buzz_prev = buzz;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout got %0d pending events required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic push_note(input int hp, input int dur, input bit rest, output int c);
        @(negedge clk);
        c                = cyc;
        note_valid       = 1'b1;
        note_half_period = hp[HP_W-1:0];
        note_dur_ms      = dur[DUR_W-1:0];
        note_rest        = rest;
        @(negedge clk);
        note_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset held with a push offered: nothing must be stored.
        rst_n            = 1'b0;
        enable           = 1'b1;
        note_valid       = 1'b1;
        note_half_period = 20'd4;
        note_dur_ms      = 16'd3;
        note_rest        = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_level", fifo_level, 0);
        rst_n      = 1'b1;
        note_valid = 1'b0;
        @(negedge clk);
        chk("rst_buzz", buzz, 0);
        chk("rst_playing", playing, 0);
        chk("rst_done", note_done, 0);
        chk("rst_level_post", fifo_level, 0);
        chk("rst_ready", note_ready, 1);
        repeat (5) @(negedge clk);
        chk("rst_nothing_stored", fifo_level, 0);

        // Single tone note hp=4, dur=3.
        push_note(4, 3, 1'b0, c);
        expect_ev(1'b0, c + 8);
        expect_ev(1'b0, c + 18);
`ifndef BUZZ_GAP_EN
        expect_ev(1'b0, c + 28);
`endif
        expect_ev(1'b1, c + 33);
        wait_until(c + 2);
        chk("single_load_not_playing", playing, 0);
        wait_until(c + 3);
        chk("single_playing", playing, 1);
        wait_until(c + 32);
        chk("single_last_play", playing, 1);
        wait_drain("single", 60);
        wait_until(c + 34);
        chk("single_idle", playing, 0);

        // Fill while paused, offer a fifth, then release.
        @(negedge clk);
        enable           = 1'b0;
        note_valid       = 1'b1;
        note_half_period = 20'd4;
        note_dur_ms      = 16'd1;
        note_rest        = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("fill_level", fifo_level, i);
        end
        chk("full_ready", note_ready, 0);
        @(negedge clk);
        @(negedge clk);
        chk("full_level_hold", fifo_level, 4);
        chk("paused_idle", playing, 0);
        note_valid = 1'b0;
        @(negedge clk);
        c      = cyc;
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifndef BUZZ_GAP_EN
            expect_ev(1'b0, c + 7 + 11 * i);
`endif
            expect_ev(1'b1, c + 12 + 11 * i);
        end
        wait_until(c + 3);
        chk("drain_level", fifo_level, 3);
        wait_drain("full", 80);
        wait_until(c + 46);
        chk("full_empty", fifo_level, 0);
        chk("full_ready_again", note_ready, 1);

        // Rest of 2 ms followed by a zero-length note.
        @(negedge clk);
        c                = cyc;
        note_valid       = 1'b1;
        note_half_period = 20'd4;
        note_dur_ms      = 16'd2;
        note_rest        = 1'b1;
        @(negedge clk);
        note_dur_ms = 16'd0;
        note_rest   = 1'b0;
        @(negedge clk);
        note_valid = 1'b0;
        expect_ev(1'b1, c + 23);
        expect_ev(1'b1, c + 24);
        wait_until(c + 3);
        chk("rest_playing", playing, 1);
        wait_until(c + 13);
        chk("rest_playing_mid", playing, 1);
        chk("rest_silent", buzz, 0);
        wait_until(c + 23);
        chk("dur0_load", playing, 0);
        wait_until(c + 24);
        chk("dur0_no_play", playing, 0);
        wait_until(c + 25);
        chk("dur0_idle", playing, 0);
        wait_drain("rest", 40);

        // Pause for 7 cycles while buzz is high.
        push_note(4, 3, 1'b0, c);
        expect_ev(1'b0, c + 8);
        expect_ev(1'b0, c + 18);
        expect_ev(1'b0, c + 27);
`ifndef BUZZ_GAP_EN
        expect_ev(1'b0, c + 35);
`endif
        expect_ev(1'b1, c + 40);
        wait_until(c + 19);
        enable = 1'b0;
        wait_until(c + 22);
        chk("pause_buzz_low", buzz, 0);
        chk("pause_playing", playing, 1);
        wait_until(c + 26);
        enable = 1'b1;
        wait_until(c + 39);
        chk("pause_last_play", playing, 1);
        wait_until(c + 40);
        chk("pause_done_idle", playing, 0);
        wait_drain("pause", 60);

        // Reset in the middle of a note with a second note queued.
        @(negedge clk);
        c                = cyc;
        note_valid       = 1'b1;
        note_half_period = 20'd4;
        note_dur_ms      = 16'd3;
        note_rest        = 1'b0;
        @(negedge clk);
        @(negedge clk);
        note_valid = 1'b0;
        expect_ev(1'b0, c + 8);
        wait_until(c + 10);
        chk("abort_queued", fifo_level, 1);
        wait_until(c + 12);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_playing", playing, 0);
        chk("abort_buzz", buzz, 0);
        chk("abort_level", fifo_level, 0);
        chk("abort_ready", note_ready, 1);
        repeat (40) @(negedge clk);
        wait_drain("abort", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
